// File: rtl/booth_arith_pkg.sv
// Shared arithmetic package for the Lab5 sequential multiplier/divider pair.
// Holds the common WAIT/CAL/FINISH state encoding and the default WIDTH/HOLD
// constants so both blocks sequence identically.
package booth_arith_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_CAL    = 2'b01,
    ST_FINISH = 2'b10
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_HOLD  = 4;

endpackage

// File: rtl/booth_divider_seq_div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in   [WIDTH:0]    partial remainder before the step
//   quo_in   [WIDTH-1:0]  dividend bits not yet consumed (MSB first) with the
//                         quotient bits developed so far shifted in at the LSB
//   divisor  [WIDTH-1:0]  divisor magnitude
//   rem_out  [WIDTH:0]    partial remainder after the step
//   quo_out  [WIDTH-1:0]  quo_in shifted left with the new quotient bit
module div_step
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  // One guard bit above the shifted remainder plus a borrow bit, so the
  // trial subtraction sign is unambiguous for every divisor magnitude.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+2:0] trial;
  logic             ge;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = {1'b0, shifted} - {3'b000, divisor};
    ge      = ~trial[WIDTH+2];
    rem_out = ge ? (WIDTH+1)'(trial) : (WIDTH+1)'(shifted);
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/booth_divider_seq.sv
// booth_divider_seq: sequential signed divider, one restoring step per clock
// on operand magnitudes, sign-corrected quotient/remainder held for HOLD
// cycles. Truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, sampled only in WAIT
//   a, b            signed dividend / divisor (WIDTH bits)
//   q, r            signed quotient / remainder, 0 outside FINISH
//   done            high exactly while in FINISH
//   dz              divide-by-zero flag, only while done=1
// Optional build macro: BOOTH_DIVIDER_DZ_DETECT_EN -- when defined, b==0 at
// the start edge jumps straight to FINISH with q=-1, r=a, dz=1. When
// undefined, CAL runs normally on b==0 and dz is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_WAIT   | idle, outputs 0, waiting for start
// ST_CAL    | one restoring step per edge, WIDTH edges total
// ST_FINISH | results presented for HOLD cycles, then back to ST_WAIT
module booth_divider_seq
  import booth_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HOLD  = DEF_HOLD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             done,
  output logic             dz
);

  // Counter is shared between the CAL step count and the FINISH hold window.
  localparam int CNT_MAX = (WIDTH > HOLD) ? WIDTH : HOLD;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q_q, sgn_q_d;
  logic             sgn_r_q, sgn_r_d;
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH:0]   rem_neg;

  // Two's-complement negation of the most negative value gives 2^(WIDTH-1),
  // which is exactly right when read back as an unsigned magnitude.
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sgn_q_d = sgn_q_q;
    sgn_r_d = sgn_r_q;
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      ST_WAIT: begin
        if (start) begin
          state_d = ST_CAL;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          sgn_q_d = a[WIDTH-1] ^ b[WIDTH-1];
          sgn_r_d = a[WIDTH-1];
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
          dz_d    = (b == '0);
          // Preload magnitudes so the normal sign fix-up yields q=-1, r=a.
          if (b == '0) begin
            state_d = ST_FINISH;
            quo_d   = '1;
            rem_d   = {1'b0, a_mag};
            sgn_q_d = 1'b0;
          end
`endif
        end
      end
      ST_CAL: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        if (cnt_q == CW'(HOLD - 1)) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sgn_q_q <= 1'b0;
      sgn_r_q <= 1'b0;
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sgn_q_q <= sgn_q_d;
      sgn_r_q <= sgn_r_d;
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign rem_neg = ~rem_q + 1'b1;

  always_comb begin
    q    = '0;
    r    = '0;
    done = 1'b0;
    dz   = 1'b0;
    if (state_q == ST_FINISH) begin
      done = 1'b1;
      q    = sgn_q_q ? (~quo_q + 1'b1) : quo_q;
      r    = sgn_r_q ? WIDTH'(rem_neg) : WIDTH'(rem_q);
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
      dz   = dz_q;
`endif
    end
  end

endmodule

// File: tb/tb_booth_divider_seq.sv
// Self-checking bench for booth_divider_seq (WIDTH=4, HOLD=4). Expected
// results come from plain integer division in a reference function.
module tb_booth_divider_seq;

  localparam int W = 4;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b, q, r;
  logic         done, dz;

  int passed = 0;
  int total  = 0;

  booth_divider_seq #(.WIDTH(W), .HOLD(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .r     (r),
    .done  (done),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: signed division truncating toward zero, remainder with the
  // dividend's sign; divide-by-zero per the build option.
  task automatic model(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                       output logic [W-1:0] eq, output logic [W-1:0] er,
                       output logic edz, output int lat);
    int ia, ib;
    ia = int'(av);
    ib = int'(bv);
    if (ib == 0) begin
      er = W'(ia);
`ifdef BOOTH_DIVIDER_DZ_DETECT_EN
      eq  = W'(-1);
      edz = 1'b1;
      lat = 0;
`else
      eq  = (ia < 0) ? W'(1) : W'(-1);
      edz = 1'b0;
      lat = W;
`endif
    end else begin
      eq  = W'(ia / ib);
      er  = W'(ia % ib);
      edz = 1'b0;
      lat = W;
    end
  endtask

  // Launch one operation and check every cycle through the end of FINISH.
  // After the start edge the operands are replaced by av2/bv2 and start is
  // left at 'hold', so later operand changes must not affect the result.
  task automatic run_op(input logic signed [W-1:0] av, input logic signed [W-1:0] bv,
                        input logic hold,
                        input logic signed [W-1:0] av2, input logic signed [W-1:0] bv2);
    logic [W-1:0] eq, er;
    logic         edz, fin;
    int           lat;
    model(av, bv, eq, er, edz, lat);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = hold; a = av2; b = bv2;
    for (int cyc = 0; cyc <= lat + H; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      fin = (cyc >= lat) && (cyc < lat + H);
      check("done", W'(done), W'(fin));
      check("q",    q,        fin ? eq : '0);
      check("r",    r,        fin ? er : '0);
      check("dz",   W'(dz),   W'(fin & edz));
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_q",    q,        '0);
    check("rst_r",    r,        '0);
    check("rst_done", W'(done), '0);
    check("rst_dz",   W'(dz),   '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op( 4'sd7,  4'sd2,  1'b0, 4'sd0, 4'sd0);
    run_op(-4'sd7,  4'sd2,  1'b0, 4'sd3, 4'sd1);
    run_op( 4'sd7, -4'sd2,  1'b0, 4'sd0, 4'sd0);
    run_op(-4'sd7, -4'sd2,  1'b0, 4'sd5, 4'sd0);
    run_op(-4'sd8, -4'sd1,  1'b0, 4'sd0, 4'sd0);
    run_op(-4'sd8,  4'sd3,  1'b0, 4'sd0, 4'sd0);
    run_op( 4'sd5,  4'sd0,  1'b0, 4'sd1, 4'sd1);
    run_op(-4'sd5,  4'sd0,  1'b0, 4'sd0, 4'sd0);
    run_op(-4'sd8,  4'sd0,  1'b0, 4'sd0, 4'sd0);
    run_op( 4'sd7, -4'sd8,  1'b0, 4'sd0, 4'sd0);

    // start held high across the whole operation with operands changed in
    // CAL; the second operation must begin only after the return to WAIT.
    run_op( 4'sd6,  4'sd3,  1'b1, 4'sd5, -4'sd2);
    run_op( 4'sd5, -4'sd2,  1'b0, 4'sd0, 4'sd0);

    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, W'($urandom), W'($urandom));
    end

    // Asynchronous reset mid-CAL.
    a = 4'sd6; b = 4'sd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("cal_rst_done", W'(done), '0);
    check("cal_rst_q",    q,        '0);
    #1 rst_n = 1'b1;
    run_op(4'sd6, 4'sd4, 1'b0, 4'sd0, 4'sd0);

    // Asynchronous reset in FINISH: outputs must drop between edges.
    a = 4'sd7; b = 4'sd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < W; i++) @(posedge clk);
    #1;
    check("fin_done", W'(done), 4'd1);
    check("fin_q",    q,        4'd3);
    #2 rst_n = 1'b0;
    #1;
    check("fin_rst_done", W'(done), '0);
    check("fin_rst_q",    q,        '0);
    check("fin_rst_r",    r,        '0);
    check("fin_rst_dz",   W'(dz),   '0);
    #1 rst_n = 1'b1;
    run_op(4'sd6, 4'sd4, 1'b0, 4'sd0, 4'sd0);
    run_op(-4'sd7, 4'sd3, 1'b0, 4'sd0, 4'sd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
